// File: rtl/ring_rdout_pkg.sv
// Shared types and constants for the ring-buffer readout scheduler.
package ring_rdout_pkg;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned SMP_W  = 7;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD   = 4'd1,
    WAIT   = 4'd2,
    READ   = 4'd3,
    NXT_CH = 4'd4,
    POP    = 4'd5
  } evt_state_e;

  // One slot of the RD -> DATA_PUSH delay line
  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
    logic            last;
  } push_t;

endpackage

// File: rtl/ring_rdout_sched_if.sv
// Control/status bundle between the readout scheduler and the ring buffers / event FIFO.
interface ring_rdout_sched_if #(
  parameter int unsigned NCH = 6
);
  logic [6:0]     SAMP_MAX;
  logic [NCH-1:0] L1A_MT;
  logic [NCH-1:0] RING_AMT;
  logic           EVT_BUF_AFL;
  logic [NCH-1:0] LD_ADDR;
  logic [NCH-1:0] RD;
  logic           NXT_L1A;
  logic           DATA_PUSH;
  logic [2:0]     DATA_CH;
  logic           LAST_WRD;
  logic           BUSY;
  logic [3:0]     EVT_STATE;

  modport master (
    input  SAMP_MAX, L1A_MT, RING_AMT, EVT_BUF_AFL,
    output LD_ADDR, RD, NXT_L1A, DATA_PUSH, DATA_CH, LAST_WRD, BUSY, EVT_STATE
  );

  modport slave (
    output SAMP_MAX, L1A_MT, RING_AMT, EVT_BUF_AFL,
    input  LD_ADDR, RD, NXT_L1A, DATA_PUSH, DATA_CH, LAST_WRD, BUSY, EVT_STATE
  );
endinterface

// File: rtl/ring_rdout_cnt.sv
// Sample/word position counters for one channel's readout, with last-word detect.
module ring_rdout_cnt
  import ring_rdout_pkg::*;
#(
  parameter int unsigned WPS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic [SMP_W-1:0] smax,
  output logic             last_c
);
  localparam int unsigned WRD_W = $clog2(WPS);

  logic [SMP_W-1:0] smp;
  logic [WRD_W-1:0] wrd;
  logic             wrd_end_c;

  assign wrd_end_c = (wrd == WRD_W'(WPS - 1));
  assign last_c    = wrd_end_c && (smp == (smax - SMP_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp <= '0;
      wrd <= '0;
    end else if (clr) begin
      smp <= '0;
      wrd <= '0;
    end else if (inc) begin
      if (wrd_end_c) begin
        wrd <= '0;
        smp <= smp + SMP_W'(1);
      end else begin
        wrd <= wrd + WRD_W'(1);
      end
    end
  end

endmodule

// File: rtl/ring_rdout_sched.sv
// Serves each L1A event from all ring-buffer channels, in channel order, into the shared event FIFO.
module ring_rdout_sched
  import ring_rdout_pkg::*;
#(
  parameter int unsigned NCH = 6,
  parameter int unsigned WPS = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  ring_rdout_sched_if.master  bus
);
  evt_state_e       state, state_nxt;
  logic [CH_W-1:0]  ch, ch_nxt;
  logic [SMP_W-1:0] smax, smax_nxt;
  logic             cnt_inc, cnt_clr, last_c, stall_c;
  logic [NCH-1:0]   ch_oh;
  push_t            push_in;
  push_t            pipe [RD_LAT];

  assign ch_oh   = NCH'(1) << ch;
  assign stall_c = bus.RING_AMT[ch] | bus.EVT_BUF_AFL;

  ring_rdout_cnt #(.WPS(WPS)) u_cnt (
    .clk    (CLK),
    .rst_n  (RST_N),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .smax   (smax),
    .last_c (last_c)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ch    <= '0;
      smax  <= '0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
      smax  <= smax_nxt;
    end
  end

  // Next state and strobes; RD is gated in the same cycle a stall condition appears
  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch;
    smax_nxt    = smax;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    bus.LD_ADDR = '0;
    bus.RD      = '0;
    bus.NXT_L1A = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.L1A_MT == '0) begin
          state_nxt = LOAD;
          ch_nxt    = '0;
          smax_nxt  = bus.SAMP_MAX;
        end
      end
      LOAD: begin
        bus.LD_ADDR = ch_oh;
        cnt_clr     = 1'b1;
        state_nxt   = (smax == '0) ? NXT_CH : WAIT;
      end
      WAIT: begin
        if (!stall_c) state_nxt = READ;
      end
      READ: begin
        if (stall_c) begin
          state_nxt = WAIT;
        end else begin
          bus.RD  = ch_oh;
          cnt_inc = 1'b1;
          if (last_c) state_nxt = NXT_CH;
        end
      end
      NXT_CH: begin
        if (ch == CH_W'(NCH - 1)) begin
          state_nxt = POP;
        end else begin
          ch_nxt    = ch + CH_W'(1);
          state_nxt = LOAD;
        end
      end
      POP: begin
        bus.NXT_L1A = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push_in.vld  = cnt_inc;
  assign push_in.ch   = ch;
  assign push_in.last = cnt_inc & last_c & (ch == CH_W'(NCH - 1));

  // Delay line matching the ring BRAM read latency
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(RD_LAT); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= push_in;
      for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign bus.DATA_PUSH = pipe[RD_LAT-1].vld;
  assign bus.DATA_CH   = pipe[RD_LAT-1].ch;
  assign bus.LAST_WRD  = pipe[RD_LAT-1].last;
  assign bus.BUSY      = (state != IDLE);
  assign bus.EVT_STATE = 4'(state);

endmodule
